// File: rtl/uncached_wbuf_ctrl.sv
// Uncached store buffer: a circular FIFO of d_cache stores drained as single-beat
// AXI writes, one outstanding at a time, with an address hazard check for loads.
module uncached_wbuf_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter logic [3:0]  WID   = 4'd1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_strb,
  input  logic [2:0]  req_size,
  input  logic [31:0] chk_addr,
  output logic        chk_hit,
  output logic        empty,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic        wr_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, RESP} state_t;

  state_t         state, state_nx;
  logic [31:0]    addr_q [DEPTH];
  logic [31:0]    data_q [DEPTH];
  logic [3:0]     strb_q [DEPTH];
  logic [2:0]     size_q [DEPTH];
  logic [PW-1:0]  head, tail, offs;
  logic [PW:0]    count;
  logic           aw_done, w_done;
  logic           push, pop, aw_hs, w_hs;
  logic           unused_ok;

  assign unused_ok = ^{bid, chk_addr[1:0]};

  assign req_ready = (count != FULL);
  assign push      = req_valid & req_ready;
  assign pop       = (state == RESP) & bvalid;
  assign aw_hs     = awvalid & awready;
  assign w_hs      = wvalid & wready;
  assign empty     = (count == '0) & (state == IDLE);

  always_ff @(posedge aclk) begin
    if (push) begin
      addr_q[tail] <= req_addr;
      data_q[tail] <= req_data;
      strb_q[tail] <= req_strb;
      size_q[tail] <= req_size;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (count != '0) state_nx = SEND;
      SEND: if ((aw_done | aw_hs) & (w_done | w_hs)) state_nx = RESP;
      RESP: if (bvalid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake flags are cleared on the way into RESP so the next SEND starts fresh.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (state == SEND) begin
      if (state_nx == RESP) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
    end
  end

  always_comb begin
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    unique case (state)
      SEND: begin
        awvalid = ~aw_done;
        wvalid  = ~w_done;
      end
      RESP:    bready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                    wr_err <= 1'b0;
    else if (pop && bresp != 2'b00)  wr_err <= 1'b1;
  end

  assign awid    = WID;
  assign wid     = WID;
  assign awlen   = '0;
  assign awburst = 2'b01;
  assign awlock  = '0;
  assign awcache = '0;
  assign awprot  = '0;
  assign wlast   = 1'b1;
  assign awaddr  = addr_q[head];
  assign awsize  = size_q[head];
  assign wdata   = data_q[head];
  assign wstrb   = strb_q[head];

  // An entry is live when its distance from head is below count; head stays live until pop.
  always_comb begin
    chk_hit = 1'b0;
    offs    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs = PW'(i) - head;
      if (({1'b0, offs} < count) && (addr_q[i][31:2] == chk_addr[31:2]))
        chk_hit = 1'b1;
    end
  end

endmodule

// File: tb/tb_uncached_wbuf_ctrl.sv
// Bench for uncached_wbuf_ctrl: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations and a randomized phase.
module tb_uncached_wbuf_ctrl;

  localparam int unsigned DEPTH = 4;

  logic        aclk, aresetn;
  logic        req_valid, req_ready;
  logic [31:0] req_addr, req_data, chk_addr;
  logic [3:0]  req_strb;
  logic [2:0]  req_size;
  logic        chk_hit, empty;
  logic [3:0]  awid, awlen, awcache, wid, wstrb, bid;
  logic [31:0] awaddr, wdata;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst, awlock, bresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready, wr_err;

  uncached_wbuf_ctrl #(.DEPTH(DEPTH), .WID(4'd1)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_strb(req_strb), .req_size(req_size),
    .chk_addr(chk_addr), .chk_hit(chk_hit), .empty(empty),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready), .wr_err(wr_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [2:0]  size;
  } ent_t;

  // Model: q holds every store not yet acknowledged; phase 0 waiting, 1 issuing, 2 awaiting B.
  ent_t        q[$];
  int          phase;
  bit          aw_got, w_got, merr;
  logic [31:0] wlog[$];
  int          errors, checks;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    phase  = 0;
    aw_got = 0;
    w_got  = 0;
    merr   = 0;
  endtask

  task automatic model_step();
    int   n;
    bit   do_push, a, w;
    ent_t e;
    n       = q.size();
    do_push = req_valid && (n != DEPTH);
    if (wvalid && wready) wlog.push_back(wdata);
    case (phase)
      0: if (n != 0) phase = 1;
      1: begin
        a = aw_got || awready;
        w = w_got || wready;
        if (a && w) begin
          phase = 2; aw_got = 0; w_got = 0;
        end else begin
          aw_got = a; w_got = w;
        end
      end
      default: if (bvalid) begin
        if (bresp != 2'b00) merr = 1;
        void'(q.pop_front());
        phase = 0;
      end
    endcase
    if (do_push) begin
      e.addr = req_addr; e.data = req_data; e.strb = req_strb; e.size = req_size;
      q.push_back(e);
    end
  endtask

  task automatic compare();
    bit hit, eaw, ew;
    hit = 0;
    foreach (q[i]) if (q[i].addr[31:2] == chk_addr[31:2]) hit = 1;
    eaw = (phase == 1) && !aw_got;
    ew  = (phase == 1) && !w_got;
    chk("req_ready", req_ready, q.size() != DEPTH);
    chk("awvalid",   awvalid,   eaw);
    chk("wvalid",    wvalid,    ew);
    chk("bready",    bready,    phase == 2);
    chk("empty",     empty,     (q.size() == 0) && (phase == 0));
    chk("chk_hit",   chk_hit,   hit);
    chk("wr_err",    wr_err,    merr);
    chk("awid",      awid,      4'd1);
    chk("wid",       wid,       4'd1);
    chk("awlen",     awlen,     0);
    chk("awburst",   awburst,   2'b01);
    chk("awlock",    awlock,    0);
    chk("awcache",   awcache,   0);
    chk("awprot",    awprot,    0);
    chk("wlast",     wlast,     1);
    if (eaw) begin
      chk("awaddr", awaddr, q[0].addr);
      chk("awsize", awsize, q[0].size);
    end
    if (ew) begin
      chk("wdata", wdata, q[0].data);
      chk("wstrb", wstrb, q[0].strb);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] a, input logic [31:0] d);
    req_valid = 1; req_addr = a; req_data = d; req_strb = 4'hF; req_size = 3'd2;
    step();
    req_valid = 0;
  endtask

  task automatic wait_ready(input string nm);
    int k = 0;
    while (!req_ready && k < 200) begin step(); k++; end
    chk(nm, req_ready, 1);
  endtask

  task automatic push_wait(input logic [31:0] a, input logic [31:0] d);
    req_addr = a; req_data = d; req_strb = 4'hF; req_size = 3'd2;
    wait_ready("push_wait_timeout");
    req_valid = 1;
    step();
    req_valid = 0;
  endtask

  task automatic wait_empty(input string nm);
    int k = 0;
    while (!empty && k < 200) begin step(); k++; end
    chk(nm, empty, 1);
  endtask

  task automatic wait_aw(input string nm);
    int k = 0;
    while (!awvalid && k < 50) begin step(); k++; end
    chk(nm, awvalid, 1);
  endtask

  initial begin
    int          base;
    logic [31:0] exp_order[$];
    errors = 0; checks = 0;
    req_valid = 0; req_addr = '0; req_data = '0; req_strb = '0; req_size = '0;
    chk_addr = '0; awready = 0; wready = 0; bid = '0; bresp = '0; bvalid = 0;
    aresetn = 0;
    model_clear();
    fork
      forever begin
        @(posedge aclk or negedge aresetn);
        if (!aresetn) model_clear();
        else          model_step();
      end
      forever begin
        @(negedge aclk);
        compare();
      end
    join_none

    #1;
    chk("rst_empty", empty, 1);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_wr_err", wr_err, 0);
    step(); step();
    aresetn = 1;
    step();

    // Single store
    push_one(32'h1FAF_F000, 32'h1234_5678);
    #1 chk("single_no_early_aw", awvalid, 0);
    step();
    chk("single_awvalid", awvalid, 1);
    chk("single_wvalid", wvalid, 1);
    chk("single_awaddr", awaddr, 32'h1FAF_F000);
    chk("single_wdata", wdata, 32'h1234_5678);
    awready = 1; wready = 1;
    step();
    awready = 0; wready = 0; bvalid = 1; bresp = 2'b00;
    #1 chk("single_bready", bready, 1);
    step();
    bvalid = 0;
    #1 chk("single_empty", empty, 1);

    // Split handshake: W lags AW by three cycles
    push_one(32'h1000_0040, 32'hA5A5_0001);
    wait_aw("split_aw_timeout");
    awready = 1; wready = 0;
    step();
    awready = 0;
    #1;
    chk("split_aw_dropped", awvalid, 0);
    chk("split_w_held", wvalid, 1);
    step(); step();
    chk("split_w_still", wvalid, 1);
    chk("split_no_resp", bready, 0);
    wready = 1;
    step();
    wready = 0;
    #1 chk("split_resp", bready, 1);
    bvalid = 1;
    step();
    bvalid = 0;
    #1 chk("split_empty", empty, 1);

    // Hazard check on word address
    push_one(32'h1FAF_F004, 32'h0BAD_F00D);
    chk_addr = 32'h1FAF_F006;
    #1 chk("hazard_hit", chk_hit, 1);
    chk_addr = 32'h1FAF_F008;
    #1 chk("hazard_miss", chk_hit, 0);
    chk_addr = 32'h1FAF_F004;
    awready = 1; wready = 1; bvalid = 1;
    wait_empty("hazard_drain_timeout");
    #1 chk("hazard_after_pop", chk_hit, 0);
    awready = 0; wready = 0; bvalid = 0;

    // Fill with AW stalled, fifth store held back
    base = wlog.size();
    for (int k = 1; k <= 4; k++) begin
      req_valid = 1; req_addr = 32'h2000_0000 + 32'(4 * k); req_data = 32'(k);
      step();
    end
    req_addr = 32'h2000_0014; req_data = 32'd5;
    #1 chk("fill_full", req_ready, 0);
    step(); step();
    chk("fill_held", req_ready, 0);
    awready = 1; wready = 1; bvalid = 1;
    wait_ready("fill_ready_timeout");
    step();
    req_valid = 0;
    wait_empty("fill_drain_timeout");
    awready = 0; wready = 0; bvalid = 0;
    chk("fill_count", wlog.size() - base, 5);
    for (int k = 1; k <= 5; k++)
      if (base + k - 1 < wlog.size()) chk("fill_order", wlog[base+k-1], 32'(k));

    // Wrap: push+pop at count 2, then ten more transactions through the ring
    base = wlog.size();
    exp_order.delete();
    awready = 1; wready = 1;
    push_one(32'h3000_0000, 32'h100);
    push_one(32'h3000_0004, 32'h101);
    step();
    chk("wrap_pre_count", dut.count, 2);
    chk("wrap_in_resp", bready, 1);
    req_valid = 1; req_addr = 32'h3000_0008; req_data = 32'h102; bvalid = 1;
    step();
    req_valid = 0; bvalid = 0;
    #1 chk("wrap_pushpop_count", dut.count, 2);
    bvalid = 1;
    for (int k = 0; k < 3; k++) exp_order.push_back(32'h100 + 32'(k));
    for (int k = 0; k < 10; k++) begin
      push_wait(32'h3000_0100 + 32'(4 * k), 32'h200 + 32'(k));
      exp_order.push_back(32'h200 + 32'(k));
    end
    wait_empty("wrap_drain_timeout");
    awready = 0; wready = 0; bvalid = 0;
    chk("wrap_count", wlog.size() - base, 13);
    foreach (exp_order[k])
      if (base + k < wlog.size()) chk("wrap_order", wlog[base+k], exp_order[k]);

    // Error response, then reset mid-SEND with three entries
    awready = 1; wready = 1; bvalid = 1; bresp = 2'b10;
    push_one(32'h4000_0000, 32'hE0E0_E0E0);
    wait_empty("err_drain_timeout");
    awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
    #1 chk("err_set", wr_err, 1);
    step(); step(); step();
    chk("err_sticky", wr_err, 1);
    push_one(32'h5000_0000, 32'h1);
    push_one(32'h5000_0004, 32'h2);
    push_one(32'h5000_0008, 32'h3);
    chk_addr = 32'h5000_0004;
    #1;
    chk("rst_mid_pre_aw", awvalid, 1);
    chk("rst_mid_pre_hit", chk_hit, 1);
    aresetn = 0;
    #1;
    chk("rst_mid_awvalid", awvalid, 0);
    chk("rst_mid_wvalid", wvalid, 0);
    chk("rst_mid_empty", empty, 1);
    chk("rst_mid_wr_err", wr_err, 0);
    chk("rst_mid_req_ready", req_ready, 1);
    chk("rst_mid_hit", chk_hit, 0);
    step();
    aresetn = 1;
    step();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_addr  = 32'h1000_0000 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
      req_data  = $urandom;
      req_strb  = 4'($urandom);
      req_size  = 3'($urandom_range(0, 2));
      chk_addr  = 32'h1000_0000 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
      awready   = ($urandom_range(0, 3) != 0);
      wready    = ($urandom_range(0, 3) != 0);
      bvalid    = ($urandom_range(0, 2) == 0);
      bresp     = ($urandom_range(0, 31) == 0) ? 2'b10 : 2'b00;
      bid       = 4'($urandom);
      if (i == 1500) begin
        aresetn = 0;
        step();
        aresetn = 1;
      end
      step();
    end
    req_valid = 0; awready = 0; wready = 0; bvalid = 0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
